divseq: RTL and testbench
=========================

# divseq

Multi-cycle restoring divider for the execution unit's DIV/IDIV instructions. It takes the same operand bus as the ALU: dividend on x, divisor on y. It returns quotient and remainder packed in the ALU's 32-bit result layout, so the exec stage can mux its output into the register write-back path. It also signals the divide-error exception (INT 0) to the microcode sequencer. The exec stage holds its operands stable and stalls while busy is high.

## Interface
- No parameters. Widths are fixed by the 8086 operand sizes.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- x  in  32  dividend; word: {DX,AX}; byte: AX in x[15:0], x[31:16] ignored
- y  in  16  divisor; byte: y[7:0] used, y[15:8] ignored
- word_op  in  1  1 = 32/16 divide, 0 = 16/8 divide
- signed_op  in  1  1 = IDIV, 0 = DIV
- out  out  32  word: {remainder, quotient}; byte: {16'h0, remainder[7:0], quotient[7:0]}
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_exc  out  1  divide error; valid only while done = 1

## Operation
- The request fields (x, y, word_op, signed_op) are latched on the start edge. Later changes to the inputs have no effect on the running operation.
- N is the iteration count: N = 16 for word, 8 for byte.
- Signed operands are converted to magnitudes. The quotient sign is the XOR of the dividend and divisor signs. The remainder sign equals the dividend sign.
- States: IDLE, CALC, FIX.
  - IDLE:
    - start with divisor == 0 -> FIX, flagged as exception.
    - start with |dividend high half| >= |divisor| -> FIX, flagged as exception. The high half is x[31:16] for word and x[15:8] for byte.
    - any other start -> CALC, with the iteration counter set to N.
  - CALC: one restoring step per cycle.
    - Shift the {partial remainder, dividend} pair left by 1.
    - Trial-subtract the divisor magnitude, using an (N+1)-bit subtractor.
    - If the trial result is non-negative, keep the difference and shift in quotient bit 1. Otherwise shift in 0.
    - After N steps -> FIX.
  - FIX:
    - Apply the quotient and remainder signs.
    - Signed range check: a quotient magnitude > 0x7FFF (word) or > 0x7F (byte) is an exception. This includes a quotient of exactly 0x8000 / 0x80, matching 8086 behaviour.
    - If there is no exception, out is registered.
    - done = 1; div_exc = the exception flag.
    - -> IDLE.
- On exception, out keeps its previous value. The microcode does not write back.
- start while busy is ignored. No queueing.
- Reset at any time forces IDLE and aborts any operation in flight, with no done pulse. Reset values: out = 0, busy = 0, done = 0, div_exc = 0.

## Timing
- start high in cycle c, normal path:
  - busy high in cycles c+1 .. c+N+1.
  - done and div_exc valid in cycle c+N+2: cycle c+18 for word, c+10 for byte.
- Pre-check exceptions (zero divisor, unsigned-magnitude overflow):
  - busy high in cycle c+1.
  - done = 1 and div_exc = 1 in cycle c+2.
- Signed range-check exceptions take the full latency.
- done lasts exactly one cycle, and busy is 0 during that cycle. A new start is accepted in the done cycle.
- out changes only on the edge that raises done on a non-exception result. It is stable at all other times.
- div_exc is 0 whenever done is 0.
- All outputs are registered.

## Test plan
- Word unsigned divide.
  - Stimulus: word_op = 1, signed_op = 0, x = 0x0001_0000, y = 0x0003, start in cycle 0.
  - Required: done in cycle 18, out = 0x0001_5555, div_exc = 0, busy high in cycles 1-17.
- Byte signed divide.
  - Stimulus: word_op = 0, signed_op = 1, x = 0xFF9C (-100), y = 0x0007.
  - Required: done in cycle 10, out = 0x0000_FEF2 (quotient -14, remainder -2).
- Divide by zero.
  - Stimulus: y = 0 in either mode, with out preloaded by a previous result.
  - Required: done in cycle 2, div_exc = 1, out unchanged.
- Unsigned overflow.
  - Stimulus: word, x = 0x0003_0000, y = 0x0003.
  - Required: done in cycle 2, div_exc = 1.
- Signed range boundary.
  - Stimulus A: word IDIV, x = 0x0000_8000, y = 0x0001.
  - Required A: done in cycle 18, div_exc = 1.
  - Stimulus B: x = 0x0000_7FFF, y = 0x0001.
  - Required B: out = 0x0000_7FFF, div_exc = 0.
- Reset mid-operation.
  - Stimulus: rst asserted in cycle 5 of a word divide.
  - Required: busy, done and out go to 0 immediately, and no done pulse follows.
  - After reset: start is issued in the cycle after rst deasserts, and the result completes normally in 18 cycles.
  - Back-to-back: a start issued in a done cycle is also accepted.

Source files
------------

// File: rtl/divseq.sv
// divseq: multi-cycle restoring divider for DIV/IDIV.
// Word mode divides 32/16 and byte mode divides 16/8. Both modes share one 16-bit datapath.
// The byte dividend is left-aligned, so after 8 shifts the quotient lands in dvd[7:0].
module divseq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [15:0] y,
    input  logic        word_op,
    input  logic        signed_op,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        div_exc
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
    state_t state, state_nxt;

    logic [15:0] rem, dvd, dsr;
    logic [4:0]  cnt;
    logic        wop, sop, q_neg, r_neg, exc;

    logic        x_neg, y_neg, pre_exc;
    logic [31:0] x32_mag;
    logic [15:0] x16_mag, y16_mag, hi_mag, lo_init, y_mag;
    logic [7:0]  y8_mag;

    // Decode the incoming request: operand magnitudes, signs and the overflow pre-check.
    always_comb begin
        x_neg   = signed_op & (word_op ? x[31] : x[15]);
        y_neg   = signed_op & (word_op ? y[15] : y[7]);
        x32_mag = x;
        if (signed_op && x[31]) x32_mag = ~x + 32'd1;
        x16_mag = x[15:0];
        if (signed_op && x[15]) x16_mag = ~x[15:0] + 16'd1;
        y16_mag = y;
        if (signed_op && y[15]) y16_mag = ~y + 16'd1;
        y8_mag  = y[7:0];
        if (signed_op && y[7])  y8_mag  = ~y[7:0] + 8'd1;
        if (word_op) begin
            hi_mag  = x32_mag[31:16];
            lo_init = x32_mag[15:0];
            y_mag   = y16_mag;
        end else begin
            hi_mag  = {8'h00, x16_mag[15:8]};
            lo_init = {x16_mag[7:0], 8'h00};
            y_mag   = {8'h00, y8_mag};
        end
        // A high half at or above the divisor means the quotient cannot fit in N bits.
        pre_exc = (y_mag == 16'd0) || (hi_mag >= y_mag);
    end

    logic [16:0] shifted, trial;
    logic        q_bit;

    // One restoring step: shift the pair left, then trial-subtract with an N+1 bit result.
    always_comb begin
        shifted = {rem, dvd[15]};
        trial   = shifted - {1'b0, dsr};
        q_bit   = ~trial[16];
    end

    logic [15:0] q_mag, q_res, r_res;
    logic        range_exc, fix_exc;
    logic [31:0] res;

    // Apply the signs and pack the result. A signed quotient must stay below 2^(N-1),
    // so a set top bit of the magnitude is an error. This includes 0x8000 and 0x80.
    always_comb begin
        q_mag     = wop ? dvd : {8'h00, dvd[7:0]};
        range_exc = sop & (wop ? dvd[15] : dvd[7]);
        fix_exc   = exc | range_exc;
        q_res     = q_neg ? ~q_mag + 16'd1 : q_mag;
        r_res     = r_neg ? ~rem + 16'd1 : rem;
        res       = wop ? {r_res, q_res} : {16'h0000, r_res[7:0], q_res[7:0]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = pre_exc ? FIX : CALC;
            CALC:    if (cnt == 5'd1) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request on start, then iterate while in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            wop   <= 1'b0;
            sop   <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            exc   <= 1'b0;
        end else if (state == IDLE && start) begin
            rem   <= hi_mag;
            dvd   <= lo_init;
            dsr   <= y_mag;
            cnt   <= word_op ? 5'd16 : 5'd8;
            wop   <= word_op;
            sop   <= signed_op;
            q_neg <= x_neg ^ y_neg;
            r_neg <= x_neg;
            exc   <= pre_exc;
        end else if (state == CALC) begin
            rem <= q_bit ? trial[15:0] : shifted[15:0];
            dvd <= {dvd[14:0], q_bit};
            cnt <= cnt - 5'd1;
        end
    end

    // Registered outputs. out is written only when a result completes without error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div_exc <= 1'b0;
        end else begin
            busy    <= (state_nxt != IDLE);
            done    <= (state == FIX);
            div_exc <= (state == FIX) && fix_exc;
            if (state == FIX && !fix_exc) out <= res;
        end
    end

endmodule

// File: tb/tb_divseq.sv
// tb_divseq: directed and randomized checks of divseq against an arithmetic reference model.
module tb_divseq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [15:0] y;
    logic        word_op;
    logic        signed_op;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        div_exc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_out = 32'h0;

    divseq dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .word_op(word_op), .signed_op(signed_op),
        .out(out), .busy(busy), .done(done), .div_exc(div_exc)
    );

    always #5 clk = ~clk;

    // Reference: truncating integer division. Latency is 2 if the divisor is zero or
    // the unsigned quotient magnitude needs more than N bits; otherwise it is N+2.
    function automatic void ref_div(input logic [31:0] xi, input logic [15:0] yi,
                                    input logic w, input logic s,
                                    output logic exc, output logic [31:0] res, output int lat);
        longint xv, yv, q, r, qa;
        int n;
        n = w ? 16 : 8;
        if (w) begin
            xv = s ? longint'($signed(xi)) : longint'(xi);
            yv = s ? longint'($signed(yi)) : longint'(yi);
        end else begin
            xv = s ? longint'($signed(xi[15:0])) : longint'(xi[15:0]);
            yv = s ? longint'($signed(yi[7:0])) : longint'(yi[7:0]);
        end
        exc = 1'b0;
        res = 32'h0;
        lat = n + 2;
        if (yv == 0) begin
            exc = 1'b1;
            lat = 2;
        end else begin
            q  = xv / yv;
            r  = xv % yv;
            qa = (q < 0) ? -q : q;
            if (qa >= (longint'(1) << n)) begin
                exc = 1'b1;
                lat = 2;
            end else if (s && qa > ((longint'(1) << (n - 1)) - 1)) begin
                exc = 1'b1;
            end else begin
                res = w ? {r[15:0], q[15:0]} : {16'h0, r[7:0], q[7:0]};
            end
        end
    endfunction

    // Issue one request and watch it to completion. Returns the done latency (0 on
    // timeout), the sampled result, and protocol or stability violations seen meanwhile.
    task automatic do_op(input logic [31:0] xi, input logic [15:0] yi, input logic w, input logic s,
                         output int lat, output logic [31:0] o, output logic e,
                         output logic proto_bad, output logic out_moved);
        bit fin;
        x = xi; y = yi; word_op = w; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = $urandom; y = 16'($urandom); word_op = 1'($urandom); signed_op = 1'($urandom);
        lat = 0; o = '0; e = 1'b0; proto_bad = 1'b0; out_moved = 1'b0; fin = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            if (done === 1'b1) begin
                fin = 1'b1;
                lat = k;
                o   = out;
                e   = div_exc;
                if (busy !== 1'b0) proto_bad = 1'b1;
            end else begin
                if (busy !== 1'b1 || div_exc !== 1'b0) proto_bad = 1'b1;
                if (out !== model_out) out_moved = 1'b1;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; word_op = 1'b0; signed_op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_exc !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", div_exc); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_unsigned;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'h0001_0000, 16'h0003, 1'b1, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != 18) begin errors++; $display("FAIL wu_lat got %0d want 18", lat); end
        checks++; if (o !== 32'h0001_5555) begin errors++; $display("FAIL wu_out got %h want 00015555", o); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wu_exc got %b want 0", e); end
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL wu_busy got bad want ok"); end
        model_out = 32'h0001_5555;
    endtask

    task automatic test_byte_signed;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'hABCD_FF9C, 16'h5507, 1'b0, 1'b1, lat, o, e, pb, om);
        checks++; if (lat != 10) begin errors++; $display("FAIL bs_lat got %0d want 10", lat); end
        checks++; if (o !== 32'h0000_FEF2) begin errors++; $display("FAIL bs_out got %h want 0000FEF2", o); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL bs_exc got %b want 0", e); end
        checks++; if (om !== 1'b0) begin errors++; $display("FAIL bs_stable got moved want stable"); end
        model_out = 32'h0000_FEF2;
    endtask

    task automatic test_div_zero;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'h1234_5678, 16'h0000, 1'b1, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != 2) begin errors++; $display("FAIL dz_word_lat got %0d want 2", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL dz_word_exc got %b want 1", e); end
        checks++; if (o !== 32'h0000_FEF2) begin errors++; $display("FAIL dz_word_out got %h want 0000FEF2", o); end
        do_op(32'h0000_0010, 16'hFF00, 1'b0, 1'b1, lat, o, e, pb, om);
        checks++; if (lat != 2) begin errors++; $display("FAIL dz_byte_lat got %0d want 2", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL dz_byte_exc got %b want 1", e); end
        checks++; if (o !== 32'h0000_FEF2) begin errors++; $display("FAIL dz_byte_out got %h want 0000FEF2", o); end
    endtask

    task automatic test_overflow;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'h0003_0000, 16'h0003, 1'b1, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != 2) begin errors++; $display("FAIL ovf_lat got %0d want 2", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_exc got %b want 1", e); end
        checks++; if (o !== 32'h0000_FEF2) begin errors++; $display("FAIL ovf_out got %h want 0000FEF2", o); end
    endtask

    task automatic test_signed_boundary;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'h0000_8000, 16'h0001, 1'b1, 1'b1, lat, o, e, pb, om);
        checks++; if (lat != 18) begin errors++; $display("FAIL sbA_lat got %0d want 18", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sbA_exc got %b want 1", e); end
        checks++; if (o !== 32'h0000_FEF2) begin errors++; $display("FAIL sbA_out got %h want 0000FEF2", o); end
        do_op(32'h0000_7FFF, 16'h0001, 1'b1, 1'b1, lat, o, e, pb, om);
        checks++; if (o !== 32'h0000_7FFF) begin errors++; $display("FAIL sbB_out got %h want 00007FFF", o); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sbB_exc got %b want 0", e); end
        model_out = 32'h0000_7FFF;
        do_op(32'hFFFF_8000, 16'h0001, 1'b1, 1'b1, lat, o, e, pb, om);
        checks++; if (lat != 18 || e !== 1'b1) begin errors++; $display("FAIL sb_neg_word got lat %0d exc %b want lat 18 exc 1", lat, e); end
        do_op(32'h0000_0080, 16'h0001, 1'b0, 1'b1, lat, o, e, pb, om);
        checks++; if (lat != 10 || e !== 1'b1) begin errors++; $display("FAIL sb_byte got lat %0d exc %b want lat 10 exc 1", lat, e); end
        do_op(32'h0000_FF81, 16'h0001, 1'b0, 1'b1, lat, o, e, pb, om);
        checks++; if (o !== 32'h0000_0081 || e !== 1'b0) begin errors++; $display("FAIL sb_byte_neg got %h exc %b want 00000081 exc 0", o, e); end
        model_out = 32'h0000_0081;
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] o; logic e, pb, om;
        do_op(32'd1000, 16'd10, 1'b1, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != 18 || o !== 32'h0000_0064) begin errors++; $display("FAIL b2b_first got lat %0d out %h want lat 18 out 00000064", lat, o); end
        model_out = 32'h0000_0064;
        do_op(32'h0000_0107, 16'h0010, 1'b0, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != 10 || o !== 32'h0000_0710) begin errors++; $display("FAIL b2b_second got lat %0d out %h want lat 10 out 00000710", lat, o); end
        model_out = 32'h0000_0710;
    endtask

    task automatic test_random;
        int lat, el; logic [31:0] o, er, xr, eo; logic [15:0] yr; logic e, ee, pb, om, w, s;
        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom);
            s  = 1'($urandom);
            xr = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) xr = ~xr + 32'd1;
            yr = 16'($urandom >> $urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) yr = ~yr + 16'd1;
            if ($urandom_range(0, 15) == 0) yr = 16'h0;
            ref_div(xr, yr, w, s, ee, er, el);
            eo = ee ? model_out : er;
            do_op(xr, yr, w, s, lat, o, e, pb, om);
            checks++; if (lat != el) begin errors++; $display("FAIL rnd_lat x=%h y=%h w=%b s=%b got %0d want %0d", xr, yr, w, s, lat, el); end
            checks++; if (e !== ee) begin errors++; $display("FAIL rnd_exc x=%h y=%h w=%b s=%b got %b want %b", xr, yr, w, s, e, ee); end
            checks++; if (o !== eo) begin errors++; $display("FAIL rnd_out x=%h y=%h w=%b s=%b got %h want %h", xr, yr, w, s, o, eo); end
            checks++; if (pb !== 1'b0) begin errors++; $display("FAIL rnd_proto x=%h y=%h got bad want ok", xr, yr); end
            checks++; if (om !== 1'b0) begin errors++; $display("FAIL rnd_stable x=%h y=%h got moved want stable", xr, yr); end
            model_out = eo;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid;
        int lat, el; logic [31:0] o, er; logic e, ee, pb, om;
        x = 32'h0012_3456; y = 16'h1234; word_op = 1'b1; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done got %b want 0", done); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL rm_out got %h want 0", out); end
        model_out = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_idle got done %b busy %b want 0 0", done, busy); end
        ref_div(32'h0012_3456, 16'h1234, 1'b1, 1'b0, ee, er, el);
        do_op(32'h0012_3456, 16'h1234, 1'b1, 1'b0, lat, o, e, pb, om);
        checks++; if (lat != el) begin errors++; $display("FAIL rm_lat got %0d want %0d", lat, el); end
        checks++; if (o !== er || e !== ee) begin errors++; $display("FAIL rm_out got %h exc %b want %h exc %b", o, e, er, ee); end
        checks++; if (pb !== 1'b0 || om !== 1'b0) begin errors++; $display("FAIL rm_proto got bad want ok"); end
    endtask

    initial begin
        test_reset();
        test_word_unsigned();
        test_byte_signed();
        test_div_zero();
        test_overflow();
        test_signed_boundary();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
